qdec_bin_sched: RTL and testbench

QDEC_BIN_SCHED -- requirements
Module: qdec_bin_sched

---
 rtl/qdec_bin_sched.sv | 228 ++++++++++++++++++++++
 tb/tb_qdec_bin_sched.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qdec_bin_sched.sv
// Bin scheduler between two bin requesters and a CABAC-style arithmetic decoder.
// Owns the context table, arbitrates requests round-robin and writes back context updates.
module qdec_bin_sched #(
  parameter int NUM_CTX = 128,
  localparam int CTX_AW = $clog2(NUM_CTX)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sliceStart_vld,
  output logic                  sliceStart_rdy,
  input  logic                  ctxWr_en,
  input  logic [CTX_AW-1:0]     ctxWr_addr,
  input  logic [6:0]            ctxWr_data,
  input  logic [1:0]            req_vld,
  output logic [1:0]            req_rdy,
  input  logic [2*CTX_AW-1:0]   req_ctxIdx,
  input  logic [1:0]            req_bypass,
  output logic [1:0]            rsp_vld,
  input  logic [1:0]            rsp_rdy,
  output logic                  rsp_bin,
  output logic                  rsp_bytealign,
  output logic                  arith_EPMode,
  output logic                  arith_mps,
  output logic                  arith_init,
  output logic [5:0]            arith_ctxState,
  output logic                  arith_ctxState_vld,
  input  logic                  arith_ctxState_rdy,
  output logic                  arith_dec_run,
  input  logic                  arith_dec_rdy,
  input  logic                  arith_ruiBin,
  input  logic                  arith_ruiBin_vld,
  output logic                  arith_ruiBin_rdy,
  input  logic                  arith_ruiBin_bytealign,
  input  logic [5:0]            arith_ctxStateUpdate,
  input  logic                  arith_ctxStateUpdate_vld,
  output logic                  arith_ctxStateUpdate_rdy,
  output logic [3:0]            dbg_state_o
);

  // Handshakes: a transfer happens on a posedge where valid and ready are both 1;
  // the producer keeps valid and its payload stable until that edge.

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_WAIT_DATA = 4'd1,
    S_INIT      = 4'd2,
    S_READY     = 4'd3,
    S_RD        = 4'd4,
    S_ISSUE     = 4'd5,
    S_WAIT_BIN  = 4'd6,
    S_WB        = 4'd7,
    S_RESP      = 4'd8
  } state_t;

  state_t              state_q, state_d;
  logic                rr_q, rr_d;
  logic                gnt_q, gnt_d;
  logic [CTX_AW-1:0]   ctx_idx_q, ctx_idx_d;
  logic                bypass_q, bypass_d;
  logic                bin_q, bin_d;
  logic                align_q, align_d;
  logic [5:0]          upd_q, upd_d;

  logic [6:0]          ctx_mem [NUM_CTX];
  logic [6:0]          ctx_rd_q;

  logic                tbl_we;
  logic [CTX_AW-1:0]   tbl_waddr;
  logic [6:0]          tbl_wdata;

  logic                gnt_any;
  logic                gnt_sel;
  logic [CTX_AW-1:0]   ctx_sel;
  logic                new_mps;

  assign dbg_state_o = state_q;

  // The rr pointer names the requester that wins a tie.
  always_comb begin
    gnt_any = 1'b0;
    gnt_sel = rr_q;
    if (req_vld[rr_q]) begin
      gnt_any = 1'b1;
      gnt_sel = rr_q;
    end else if (req_vld[~rr_q]) begin
      gnt_any = 1'b1;
      gnt_sel = ~rr_q;
    end
  end

  assign ctx_sel = gnt_sel ? req_ctxIdx[2*CTX_AW-1:CTX_AW] : req_ctxIdx[CTX_AW-1:0];

  // MPS flips only when an LPS is decoded from the equiprobable state.
  assign new_mps = ((bin_q != ctx_rd_q[6]) && (ctx_rd_q[5:0] == 6'd0)) ? ~ctx_rd_q[6] : ctx_rd_q[6];

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    gnt_d     = gnt_q;
    ctx_idx_d = ctx_idx_q;
    bypass_d  = bypass_q;
    bin_d     = bin_q;
    align_d   = align_q;
    upd_d     = upd_q;

    sliceStart_rdy           = 1'b0;
    req_rdy                  = 2'b00;
    rsp_vld                  = 2'b00;
    rsp_bin                  = 1'b0;
    rsp_bytealign            = 1'b0;
    arith_EPMode             = 1'b0;
    arith_mps                = 1'b0;
    arith_init               = 1'b0;
    arith_ctxState           = 6'd0;
    arith_ctxState_vld       = 1'b0;
    arith_dec_run            = 1'b0;
    arith_ruiBin_rdy         = 1'b0;
    arith_ctxStateUpdate_rdy = 1'b0;

    tbl_we    = 1'b0;
    tbl_waddr = ctxWr_addr;
    tbl_wdata = ctxWr_data;

    case (state_q)
      S_IDLE: begin
        sliceStart_rdy = 1'b1;
        tbl_we         = ctxWr_en;
        if (sliceStart_vld) state_d = S_WAIT_DATA;
      end
      S_WAIT_DATA: begin
        tbl_we = ctxWr_en;
        if (arith_dec_rdy) state_d = S_INIT;
      end
      S_INIT: begin
        tbl_we     = ctxWr_en;
        arith_init = 1'b1;
        state_d    = S_READY;
      end
      S_READY: begin
        tbl_we = ctxWr_en;
        // A pending slice start outranks any bin request.
        if (sliceStart_vld) begin
          sliceStart_rdy = 1'b1;
          state_d        = S_WAIT_DATA;
        end else if (gnt_any) begin
          req_rdy[gnt_sel] = 1'b1;
          gnt_d            = gnt_sel;
          rr_d             = ~gnt_sel;
          ctx_idx_d        = ctx_sel;
          bypass_d         = req_bypass[gnt_sel];
          state_d          = S_RD;
        end else begin
          sliceStart_rdy = 1'b1;
        end
      end
      S_RD: begin
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (arith_dec_rdy && (bypass_q || arith_ctxState_rdy)) begin
          arith_dec_run      = 1'b1;
          arith_EPMode       = bypass_q;
          arith_ctxState_vld = ~bypass_q;
          if (!bypass_q) begin
            arith_ctxState = ctx_rd_q[5:0];
            arith_mps      = ctx_rd_q[6];
          end
          state_d = S_WAIT_BIN;
        end
      end
      S_WAIT_BIN: begin
        arith_ruiBin_rdy         = 1'b1;
        arith_ctxStateUpdate_rdy = 1'b1;
        if (arith_ruiBin_vld) begin
          bin_d   = arith_ruiBin;
          align_d = arith_ruiBin_bytealign;
          // Without a fresh update the entry keeps its old state.
          upd_d   = arith_ctxStateUpdate_vld ? arith_ctxStateUpdate : ctx_rd_q[5:0];
          state_d = bypass_q ? S_RESP : S_WB;
        end
      end
      S_WB: begin
        tbl_we    = 1'b1;
        tbl_waddr = ctx_idx_q;
        tbl_wdata = {new_mps, upd_q};
        state_d   = S_RESP;
      end
      S_RESP: begin
        rsp_vld[gnt_q] = 1'b1;
        rsp_bin        = bin_q;
        rsp_bytealign  = align_q;
        if (rsp_rdy[gnt_q]) state_d = S_READY;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rr_q      <= 1'b0;
      gnt_q     <= 1'b0;
      ctx_idx_q <= '0;
      bypass_q  <= 1'b0;
      bin_q     <= 1'b0;
      align_q   <= 1'b0;
      upd_q     <= 6'd0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      gnt_q     <= gnt_d;
      ctx_idx_q <= ctx_idx_d;
      bypass_q  <= bypass_d;
      bin_q     <= bin_d;
      align_q   <= align_d;
      upd_q     <= upd_d;
    end
  end

  // Context table is not cleared by reset; a reset cycle blocks any write.
  always_ff @(posedge clk) begin
    if (tbl_we && !rst) ctx_mem[tbl_waddr] <= tbl_wdata;
    if ((state_q == S_RD) && !bypass_q) ctx_rd_q <= ctx_mem[ctx_idx_q];
  end

endmodule

// File: tb/tb_qdec_bin_sched.sv
// Directed bench for qdec_bin_sched: slice init, regular/bypass bins, arbitration,
// response back-pressure and mid-bin reset, with hand-computed expectations.
module tb_qdec_bin_sched;

  localparam int CTX_AW = 7;
  localparam logic [3:0] ST_IDLE = 4'd0, ST_WAIT_DATA = 4'd1, ST_READY = 4'd3;

  logic              clk = 1'b0;
  logic              rst;
  logic              sliceStart_vld, sliceStart_rdy;
  logic              ctxWr_en;
  logic [CTX_AW-1:0] ctxWr_addr;
  logic [6:0]        ctxWr_data;
  logic [1:0]        req_vld, req_rdy, req_bypass;
  logic [2*CTX_AW-1:0] req_ctxIdx;
  logic [1:0]        rsp_vld, rsp_rdy;
  logic              rsp_bin, rsp_bytealign;
  logic              arith_EPMode, arith_mps, arith_init;
  logic [5:0]        arith_ctxState;
  logic              arith_ctxState_vld, arith_ctxState_rdy;
  logic              arith_dec_run, arith_dec_rdy;
  logic              arith_ruiBin, arith_ruiBin_vld, arith_ruiBin_rdy, arith_ruiBin_bytealign;
  logic [5:0]        arith_ctxStateUpdate;
  logic              arith_ctxStateUpdate_vld, arith_ctxStateUpdate_rdy;
  logic [3:0]        dbg_state;

  int checks = 0;
  int failures = 0;

  qdec_bin_sched #(.NUM_CTX(128)) dut (
    .clk(clk), .rst(rst),
    .sliceStart_vld(sliceStart_vld), .sliceStart_rdy(sliceStart_rdy),
    .ctxWr_en(ctxWr_en), .ctxWr_addr(ctxWr_addr), .ctxWr_data(ctxWr_data),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_ctxIdx(req_ctxIdx), .req_bypass(req_bypass),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_bin(rsp_bin), .rsp_bytealign(rsp_bytealign),
    .arith_EPMode(arith_EPMode), .arith_mps(arith_mps), .arith_init(arith_init),
    .arith_ctxState(arith_ctxState), .arith_ctxState_vld(arith_ctxState_vld),
    .arith_ctxState_rdy(arith_ctxState_rdy), .arith_dec_run(arith_dec_run),
    .arith_dec_rdy(arith_dec_rdy), .arith_ruiBin(arith_ruiBin), .arith_ruiBin_vld(arith_ruiBin_vld),
    .arith_ruiBin_rdy(arith_ruiBin_rdy), .arith_ruiBin_bytealign(arith_ruiBin_bytealign),
    .arith_ctxStateUpdate(arith_ctxStateUpdate), .arith_ctxStateUpdate_vld(arith_ctxStateUpdate_vld),
    .arith_ctxStateUpdate_rdy(arith_ctxStateUpdate_rdy), .dbg_state_o(dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after posedge; outputs are sampled 2 units later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic ctx_write(input int addr, input logic [6:0] data);
    ctxWr_en   = 1'b1;
    ctxWr_addr = addr[CTX_AW-1:0];
    ctxWr_data = data;
    next_cycle();
    ctxWr_en = 1'b0;
  endtask

  task automatic slice_start(input int dly);
    logic early;
    int inits;
    if (dly > 0) arith_dec_rdy = 1'b0;
    sliceStart_vld = 1'b1;
    #2 check("ss_rdy", sliceStart_rdy, 1);
    next_cycle();
    sliceStart_vld = 1'b0;
    #2 check("ss_wait_state", dbg_state, ST_WAIT_DATA);
    check("ss_busy_rdy", sliceStart_rdy, 0);
    early = 1'b0;
    for (int d = 0; d < dly; d++) begin
      if (arith_init) early = 1'b1;
      next_cycle();
      #2;
    end
    arith_dec_rdy = 1'b1;
    inits = 0;
    for (int k = 0; k < 4; k++) begin
      inits += int'(arith_init);
      next_cycle();
      #2;
    end
    check("init_early", early, 0);
    check("init_count", inits, 1);
    check("init_to_ready", dbg_state, ST_READY);
  endtask

  task automatic run_bin(input logic [1:0] vld, input logic [1:0] byp, input int c0, input int c1,
                         input logic [1:0] exp_g, input logic dbin, input logic [5:0] dupd,
                         input logic dalign, input logic [5:0] exp_state, input logic exp_mps,
                         input int stall, input int hold, input bit keep, input bit abort);
    logic [1:0] g;
    logic byp_g, seen;
    logic [6:0] c0v, c1v, ctx_g;
    int lat;
    c0v = c0[6:0];
    c1v = c1[6:0];
    req_vld    = vld;
    req_bypass = byp;
    req_ctxIdx = {c1v, c0v};
    g = 2'b00;
    for (int n = 0; n < 20; n++) begin
      #2;
      if (req_rdy != 2'b00) begin
        g = req_rdy;
        break;
      end
      next_cycle();
    end
    check("grant", g, exp_g);
    if (g == 2'b00) begin
      req_vld = 2'b00;
      return;
    end
    byp_g = byp[g[1]];
    ctx_g = g[1] ? c1v : c0v;
    next_cycle();
    if (!keep) req_vld = 2'b00;
    lat = 1;
    for (int n = 0; n < 30; n++) begin
      arith_ctxState_rdy = (lat >= 2 + stall);
      #2;
      if (arith_dec_run) break;
      lat++;
      next_cycle();
    end
    arith_ctxState_rdy = 1'b1;
    check("run_lat", lat, byp_g ? 2 : 2 + stall);
    check("ep_mode", arith_EPMode, byp_g);
    check("state_vld", arith_ctxState_vld, !byp_g);
    if (!byp_g) begin
      check("ctx_state", arith_ctxState, exp_state);
      check("ctx_mps", arith_mps, exp_mps);
    end
    next_cycle();
    #2 check("run_pulse", arith_dec_run, 0);
    check("bin_rdys", {arith_ruiBin_rdy, arith_ctxStateUpdate_rdy}, 2'b11);
    if (abort) begin
      sliceStart_vld = 1'b1;
      ctxWr_en = 1'b1;
      ctxWr_addr = ctx_g;
      ctxWr_data = 7'h7F;
      #2 check("ss_blocked", sliceStart_rdy, 0);
      next_cycle();
      sliceStart_vld = 1'b0;
      ctxWr_en = 1'b0;
      rst = 1'b1;
      arith_ruiBin_vld = 1'b1;
      arith_ruiBin = 1'b1;
      arith_ctxStateUpdate = 6'd40;
      arith_ctxStateUpdate_vld = 1'b1;
      next_cycle();
      rst = 1'b0;
      arith_ruiBin_vld = 1'b0;
      arith_ctxStateUpdate_vld = 1'b0;
      #2 check("rst_idle", dbg_state, ST_IDLE);
      seen = 1'b0;
      for (int n = 0; n < 6; n++) begin
        if (rsp_vld != 2'b00) seen = 1'b1;
        next_cycle();
        #2;
      end
      check("rst_no_rsp", seen, 0);
      return;
    end
    next_cycle();
    arith_ruiBin_vld = 1'b1;
    arith_ruiBin = dbin;
    arith_ruiBin_bytealign = dalign;
    arith_ctxStateUpdate = dupd;
    arith_ctxStateUpdate_vld = 1'b1;
    next_cycle();
    arith_ruiBin_vld = 1'b0;
    arith_ctxStateUpdate_vld = 1'b0;
    lat = 1;
    for (int n = 0; n < 20; n++) begin
      #2;
      if (rsp_vld != 2'b00) break;
      lat++;
      next_cycle();
    end
    check("rsp_lat", lat, byp_g ? 1 : 2);
    check("rsp_vld", rsp_vld, exp_g);
    check("rsp_bin", rsp_bin, dbin);
    check("rsp_align", rsp_bytealign, dalign);
    for (int h = 0; h < hold; h++) begin
      req_vld = 2'b11;
      req_bypass = 2'b00;
      next_cycle();
      #2 check("rsp_hold", {rsp_vld, rsp_bin, rsp_bytealign, arith_dec_run, req_rdy},
                           {exp_g, dbin, dalign, 1'b0, 2'b00});
    end
    if (hold > 0) req_vld = 2'b00;
    rsp_rdy = exp_g;
    next_cycle();
    rsp_rdy = 2'b00;
    #2 check("rsp_done", rsp_vld, 0);
    check("back_ready", dbg_state, ST_READY);
  endtask

  initial begin
    rst = 1'b1;
    sliceStart_vld = 1'b0;
    ctxWr_en = 1'b0;
    ctxWr_addr = '0;
    ctxWr_data = '0;
    req_vld = 2'b00;
    req_bypass = 2'b00;
    req_ctxIdx = '0;
    rsp_rdy = 2'b00;
    arith_ctxState_rdy = 1'b1;
    arith_dec_rdy = 1'b0;
    arith_ruiBin = 1'b0;
    arith_ruiBin_vld = 1'b0;
    arith_ruiBin_bytealign = 1'b0;
    arith_ctxStateUpdate = 6'd0;
    arith_ctxStateUpdate_vld = 1'b0;
    repeat (3) next_cycle();
    #2 check("reset_outputs",
             {sliceStart_rdy, req_rdy, rsp_vld, rsp_bin, rsp_bytealign, arith_EPMode, arith_mps,
              arith_init, arith_ctxState, arith_ctxState_vld, arith_dec_run, arith_ruiBin_rdy,
              arith_ctxStateUpdate_rdy}, 20'h80000);
    check("reset_state", dbg_state, ST_IDLE);
    next_cycle();
    rst = 1'b0;

    ctx_write(5, 7'h40);
    slice_start(5);
    ctx_write(9, 7'h4A);
    ctx_write(20, 7'h03);

    // ctx5 {1,0}: LPS from state 0 flips mps -> {0,0}
    run_bin(2'b01, 2'b00, 5, 0, 2'b01, 1'b0, 6'd0, 1'b0, 6'd0, 1'b1, 0, 0, 0, 0);
    run_bin(2'b01, 2'b00, 5, 0, 2'b01, 1'b0, 6'd0, 1'b1, 6'd0, 1'b0, 0, 0, 0, 0);
    // ctx9 {1,10}: LPS from nonzero state keeps mps -> {1,7}; ctxState_rdy stalls 3 cycles
    run_bin(2'b10, 2'b00, 0, 9, 2'b10, 1'b0, 6'd7, 1'b0, 6'd10, 1'b1, 3, 0, 0, 0);
    run_bin(2'b10, 2'b00, 0, 9, 2'b10, 1'b1, 6'd7, 1'b1, 6'd7, 1'b1, 0, 0, 0, 0);

    // Both requesters bypass, held high: grants alternate 0,1,0,1
    run_bin(2'b11, 2'b11, 5, 9, 2'b01, 1'b1, 6'd42, 1'b0, 6'd0, 1'b0, 2, 0, 1, 0);
    run_bin(2'b11, 2'b11, 5, 9, 2'b10, 1'b0, 6'd42, 1'b1, 6'd0, 1'b0, 0, 0, 1, 0);
    run_bin(2'b11, 2'b11, 5, 9, 2'b01, 1'b1, 6'd42, 1'b1, 6'd0, 1'b0, 0, 0, 1, 0);
    run_bin(2'b11, 2'b11, 5, 9, 2'b10, 1'b0, 6'd42, 1'b0, 6'd0, 1'b0, 0, 0, 0, 0);
    run_bin(2'b01, 2'b00, 9, 0, 2'b01, 1'b1, 6'd7, 1'b0, 6'd7, 1'b1, 0, 0, 0, 0);

    // Slice start and a request together in READY: slice start wins
    sliceStart_vld = 1'b1;
    req_vld = 2'b01;
    req_bypass = 2'b00;
    req_ctxIdx = {7'd0, 7'd5};
    #2 check("ss_vs_req", {sliceStart_rdy, req_rdy}, 3'b100);
    next_cycle();
    sliceStart_vld = 1'b0;
    #2 check("ss_wins_state", dbg_state, ST_WAIT_DATA);
    // ctx5 {0,0}: LPS bin 1 from state 0 -> {1,0}; response held off for 10 cycles
    run_bin(2'b01, 2'b00, 5, 0, 2'b01, 1'b1, 6'd0, 1'b1, 6'd0, 1'b0, 0, 10, 0, 0);
    run_bin(2'b01, 2'b00, 5, 0, 2'b01, 1'b1, 6'd0, 1'b0, 6'd0, 1'b1, 0, 0, 0, 0);

    // Reset while waiting for the bin: no response, ctx20 stays {0,3}
    run_bin(2'b01, 2'b00, 20, 0, 2'b01, 1'b1, 6'd40, 1'b0, 6'd3, 1'b0, 0, 0, 0, 1);
    slice_start(0);
    run_bin(2'b01, 2'b00, 20, 0, 2'b01, 1'b0, 6'd3, 1'b0, 6'd3, 1'b0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
